note_scheduler: RTL and testbench

Game-level controller for the note shift/load datapath.
- Latches the song selection and generates the per-song step tick that drives the shifter's pixel offset and note index.
- Handles start, pause, abort and finish sequencing.
- Judges red/blue hit buttons against the judgement-column notes and issues the note-clear pulse.
- Maintains combo, max-combo and score.

---
 rtl/note_sched_pkg.sv | 57 +++++
 rtl/step_divider.sv | 35 +++
 rtl/note_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_note_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/note_sched_pkg.sv
// note_sched_pkg: shared types, default song tables and small helpers for
// the note scheduler.
//   state_e            game state {IDLE, PLAY, PAUSE, FINISH}
//   SPEEDn_DEF/LENn_DEF default divider terminal counts and note counts
//   song_speed/song_len per-song lookup (song 0 falls back to song 1)
//   sat_inc8/sat_add16 saturating arithmetic for combo and score
package note_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        PAUSE  = 2'd2,
        FINISH = 2'd3
    } state_e;

    localparam logic [16:0] SPEED1_DEF  = 17'd29999;
    localparam logic [16:0] SPEED2_DEF  = 17'd24999;
    localparam logic [16:0] SPEED3_DEF  = 17'd49999;
    localparam logic [9:0]  LEN1_DEF    = 10'd144;
    localparam logic [9:0]  LEN2_DEF    = 10'd240;
    localparam logic [9:0]  LEN3_DEF    = 10'd240;
    localparam logic [15:0] HIT_PTS_DEF = 16'd10;

    function automatic logic [16:0] song_speed(input logic [1:0]  song,
                                               input logic [16:0] s1,
                                               input logic [16:0] s2,
                                               input logic [16:0] s3);
        case (song)
            2'd2:    return s2;
            2'd3:    return s3;
            default: return s1;
        endcase
    endfunction

    function automatic logic [9:0] song_len(input logic [1:0] song,
                                            input logic [9:0] l1,
                                            input logic [9:0] l2,
                                            input logic [9:0] l3);
        case (song)
            2'd2:    return l2;
            2'd3:    return l3;
            default: return l1;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                              input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/step_divider.sv
// step_divider: free-running step divider for the scheduler.
//   clk, rst   clock, synchronous active-high reset
//   clr        restart the count at 0 (new song / abort)
//   en         count enable; low freezes the count in place (pause)
//   term       terminal count for the current song
//   at_term    combinational: this cycle is the terminal cycle
//   step_tick  registered one-cycle pulse following the terminal cycle
module step_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [16:0] term,
    output logic        at_term,
    output logic        step_tick
);

    logic [16:0] count;

    assign at_term = en && (count == term);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count     <= 17'd0;
            step_tick <= 1'b0;
        end else begin
            step_tick <= at_term;
            if (at_term)
                count <= 17'd0;
            else if (en)
                count <= count + 17'd1;
        end
    end

endmodule

// File: rtl/note_scheduler.sv
// note_scheduler: game-level controller for the note shift/load datapath.
// Sequences start/pause/abort/finish, generates the pixel step tick,
// judges hits against the judgement column and keeps combo/score.
//   clk, rst              clock, synchronous active-high reset
//   start_btn, pause_btn  single-cycle button pulses
//   song_sel              song select (0 = none)
//   red_hit, blue_hit     hit button pulses
//   judge_r, judge_b      notes present at the judgement column
//   step_tick, note_advance, offset, note_index  shifter timing
//   clear_judge           delete pulse for the judged note
//   cur_song, playing, finish, combo, max_combo, score  game status
// Build option: define PERFECT_WINDOW_EN to double the score of a hit
// landing while offset is 2..4.
module note_scheduler
    import note_sched_pkg::*;
#(
    parameter logic [16:0] SPEED1  = SPEED1_DEF,
    parameter logic [16:0] SPEED2  = SPEED2_DEF,
    parameter logic [16:0] SPEED3  = SPEED3_DEF,
    parameter logic [9:0]  LEN1    = LEN1_DEF,
    parameter logic [9:0]  LEN2    = LEN2_DEF,
    parameter logic [9:0]  LEN3    = LEN3_DEF,
    parameter logic [15:0] HIT_PTS = HIT_PTS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_btn,
    input  logic        pause_btn,
    input  logic [1:0]  song_sel,
    input  logic        red_hit,
    input  logic        blue_hit,
    input  logic        judge_r,
    input  logic        judge_b,
    output logic        step_tick,
    output logic        note_advance,
    output logic [2:0]  offset,
    output logic [9:0]  note_index,
    output logic        clear_judge,
    output logic [1:0]  cur_song,
    output logic        playing,
    output logic        finish,
    output logic [7:0]  combo,
    output logic [7:0]  max_combo,
    output logic [15:0] score
);

    state_e      state;
    logic        hit_flag;
    logic [16:0] term;
    logic [9:0]  len;
    logic        at_term;
    logic        start_play, abort;
    logic        in_play, press, valid_hit, adv, last_note, miss;
    logic [7:0]  combo_inc;
    logic [15:0] hit_pts;

    assign term = song_speed(cur_song, SPEED1, SPEED2, SPEED3);
    assign len  = song_len(cur_song, LEN1, LEN2, LEN3);

    assign in_play    = (state == PLAY);
    assign start_play = (state == IDLE) && start_btn && (song_sel != 2'd0);
    assign abort      = (state == PAUSE) && start_btn;

    step_divider u_div (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_play | abort),
        .en        (in_play),
        .term      (term),
        .at_term   (at_term),
        .step_tick (step_tick)
    );

    // at_term is only ever high in PLAY, so adv is already play-qualified.
    assign adv       = at_term && (offset == 3'd6);
    assign last_note = (note_index == len - 10'd1);
    assign press     = in_play && (red_hit || blue_hit);
    assign valid_hit = in_play && !hit_flag &&
                       ((red_hit && judge_r && !blue_hit) ||
                        (blue_hit && judge_b && !red_hit));
    // A hit landing on the advance cycle belongs to the outgoing note, so it
    // suppresses the miss for that note.
    assign miss      = adv && (judge_r || judge_b) && !hit_flag && !valid_hit;
    assign combo_inc = sat_inc8(combo);

`ifdef PERFECT_WINDOW_EN
    assign hit_pts = (offset >= 3'd2 && offset <= 3'd4) ?
                     sat_add16(HIT_PTS, HIT_PTS) : HIT_PTS;
`else
    assign hit_pts = HIT_PTS;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            hit_flag     <= 1'b0;
            note_advance <= 1'b0;
            offset       <= 3'd0;
            note_index   <= 10'd0;
            clear_judge  <= 1'b0;
            cur_song     <= 2'd0;
            playing      <= 1'b0;
            finish       <= 1'b0;
            combo        <= 8'd0;
            max_combo    <= 8'd0;
            score        <= 16'd0;
        end else begin
            note_advance <= 1'b0;
            clear_judge  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_play) begin
                        state      <= PLAY;
                        playing    <= 1'b1;
                        cur_song   <= song_sel;
                        offset     <= 3'd0;
                        note_index <= 10'd0;
                        combo      <= 8'd0;
                        max_combo  <= 8'd0;
                        score      <= 16'd0;
                        hit_flag   <= 1'b0;
                    end
                end
                PLAY: begin
                    if (at_term) begin
                        if (offset == 3'd6) begin
                            offset       <= 3'd0;
                            note_advance <= 1'b1;
                            if (!last_note)
                                note_index <= note_index + 10'd1;
                        end else begin
                            offset <= offset + 3'd1;
                        end
                    end
                    if (valid_hit) begin
                        clear_judge <= 1'b1;
                        combo       <= combo_inc;
                        if (combo_inc > max_combo)
                            max_combo <= combo_inc;
                        score       <= sat_add16(score, hit_pts);
                        hit_flag    <= 1'b1;
                    end else if (press || miss) begin
                        combo <= 8'd0;
                    end
                    // Placed after the hit update so the new note starts clean.
                    if (adv)
                        hit_flag <= 1'b0;
                    // Song end outranks a pause arriving in the same cycle.
                    if (adv && last_note) begin
                        state   <= FINISH;
                        playing <= 1'b0;
                        finish  <= 1'b1;
                    end else if (pause_btn) begin
                        state   <= PAUSE;
                        playing <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (start_btn) begin
                        state      <= IDLE;
                        cur_song   <= 2'd0;
                        offset     <= 3'd0;
                        note_index <= 10'd0;
                        combo      <= 8'd0;
                        max_combo  <= 8'd0;
                        score      <= 16'd0;
                        hit_flag   <= 1'b0;
                    end else if (pause_btn) begin
                        state   <= PLAY;
                        playing <= 1'b1;
                    end
                end
                FINISH: begin
                    if (start_btn) begin
                        state  <= IDLE;
                        finish <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_scheduler.sv
// tb_note_scheduler: directed and randomized checks of note_scheduler
// against a tick-count reference model (offset/index derived from the
// total number of pixel steps taken).
module tb_note_scheduler;

    localparam int SP1 = 9, SP2 = 1, SP3 = 4;
    localparam int L1 = 4, L2 = 300, L3 = 5;
    localparam int PTS = 10;
    localparam int S_IDLE = 0, S_PLAY = 1, S_PAUSE = 2, S_FIN = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_btn = 1'b0, pause_btn = 1'b0;
    logic [1:0]  song_sel = 2'd0;
    logic        red_hit = 1'b0, blue_hit = 1'b0;
    logic        judge_r = 1'b0, judge_b = 1'b0;
    logic        step_tick, note_advance, clear_judge, playing, finish;
    logic [2:0]  offset;
    logic [9:0]  note_index;
    logic [1:0]  cur_song;
    logic [7:0]  combo, max_combo;
    logic [15:0] score;

    note_scheduler #(
        .SPEED1(17'd9), .SPEED2(17'd1), .SPEED3(17'd4),
        .LEN1(10'd4), .LEN2(10'd300), .LEN3(10'd5), .HIT_PTS(16'd10)
    ) dut (
        .clk(clk), .rst(rst), .start_btn(start_btn), .pause_btn(pause_btn),
        .song_sel(song_sel), .red_hit(red_hit), .blue_hit(blue_hit),
        .judge_r(judge_r), .judge_b(judge_b), .step_tick(step_tick),
        .note_advance(note_advance), .offset(offset), .note_index(note_index),
        .clear_judge(clear_judge), .cur_song(cur_song), .playing(playing),
        .finish(finish), .combo(combo), .max_combo(max_combo), .score(score)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_st = S_IDLE, m_song = 0, m_ticks = 0, m_phase = 0;
    int m_combo = 0, m_max = 0, m_score = 0;
    bit m_hit = 0, m_tick = 0, m_adv = 0, m_clr = 0;

    function automatic int spd(input int s);
        return (s == 2) ? SP2 : (s == 3) ? SP3 : SP1;
    endfunction
    function automatic int ln(input int s);
        return (s == 2) ? L2 : (s == 3) ? L3 : L1;
    endfunction

    task automatic clear_all();
        m_st = S_IDLE; m_song = 0; m_ticks = 0; m_phase = 0;
        m_combo = 0; m_max = 0; m_score = 0; m_hit = 0;
    endtask

    task automatic model_step();
        int off, pts;
        bit tick, last, valid;
        m_tick = 0; m_adv = 0; m_clr = 0;
        if (rst) begin
            clear_all();
            return;
        end
        case (m_st)
            S_IDLE: if (start_btn && song_sel != 0) begin
                clear_all();
                m_song = int'(song_sel);
                m_st = S_PLAY;
            end
            S_PLAY: begin
                off  = m_ticks % 7;
                tick = (m_phase == spd(m_song));
                m_phase = tick ? 0 : m_phase + 1;
                m_tick = tick;
                m_adv  = tick && off == 6;
                last   = m_adv && (m_ticks + 1 == 7 * ln(m_song));
                if (tick) m_ticks++;
                valid = !m_hit && ((red_hit && judge_r && !blue_hit) ||
                                   (blue_hit && judge_b && !red_hit));
                pts = PTS;
`ifdef PERFECT_WINDOW_EN
                if (off >= 2 && off <= 4) pts = 2 * PTS;
`endif
                if (valid) begin
                    m_combo = (m_combo + 1 > 255) ? 255 : m_combo + 1;
                    if (m_combo > m_max) m_max = m_combo;
                    m_score = (m_score + pts > 65535) ? 65535 : m_score + pts;
                    m_hit = 1;
                    m_clr = 1;
                end else if (red_hit || blue_hit) begin
                    m_combo = 0;
                end
                if (m_adv) begin
                    if ((judge_r || judge_b) && !m_hit) m_combo = 0;
                    m_hit = 0;
                end
                if (last) m_st = S_FIN;
                else if (pause_btn) m_st = S_PAUSE;
            end
            S_PAUSE: begin
                if (start_btn) clear_all();
                else if (pause_btn) m_st = S_PLAY;
            end
            default: if (start_btn) m_st = S_IDLE;
        endcase
    endtask

    function automatic logic [51:0] model_vec();
        int idx;
        idx = m_ticks / 7;
        if (idx > ln(m_song) - 1) idx = ln(m_song) - 1;
        return {m_tick, m_adv, 3'(m_ticks % 7), 10'(idx), m_clr, 2'(m_song),
                m_st == S_PLAY, m_st == S_FIN, 8'(m_combo), 8'(m_max), 16'(m_score)};
    endfunction

    // One clock: DUT and model consume the same inputs, outputs compared
    // 1 ns after the edge, then the pulse inputs drop.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("outs", {step_tick, note_advance, offset, note_index, clear_judge, cur_song,
                     playing, finish, combo, max_combo, score}, model_vec());
        start_btn = 0; pause_btn = 0; red_hit = 0; blue_hit = 0;
    endtask

    int tcnt;
    logic [2:0] frozen_off;

    initial begin
        // reset
        rst = 1; step(); step();
        rst = 0;
        chk("rst_state", {offset, note_index, combo, max_combo, score, playing, finish, cur_song}, 0);

        // start with no song is ignored
        song_sel = 0; start_btn = 1; step();
        chk("sel0_idle", playing, 0);
        step();

        // song 1: hit, double hit
        song_sel = 1; start_btn = 1; step();
        chk("play", playing, 1);
        chk("song1", cur_song, 1);
        judge_r = 1; red_hit = 1; step();
        chk("hit_clear", clear_judge, 1);
        chk("hit_combo", combo, 1);
        chk("hit_score", score, 10);
        step();
        chk("clear_once", clear_judge, 0);
        red_hit = 1; step();
        chk("dbl_combo", combo, 0);
        chk("dbl_score", score, 10);

        for (int i = 0; i < 200; i++) begin
            step();
            if (note_advance) break;
        end
        chk("first_adv", note_advance, 1);
        red_hit = 1; step();
        chk("hit2_combo", combo, 1);
        step();
        red_hit = 1; blue_hit = 1; step();
        chk("both_combo", combo, 0);
        chk("both_noclr", clear_judge, 0);

        // pause freezes the step timing
        step(); step(); step();
        pause_btn = 1; step();
        chk("paused", playing, 0);
        frozen_off = 3'(m_ticks % 7);
        tcnt = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (step_tick) tcnt++;
        end
        chk("pause_noticks", tcnt, 0);
        chk("pause_off", offset, frozen_off);
        pause_btn = 1; step();
        chk("resumed", playing, 1);

        // run to the end of song 1
        judge_r = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (finish) break;
        end
        chk("fin_flag", finish, 1);
        chk("fin_index", note_index, 3);
        start_btn = 1; step();
        chk("fin_exit", {playing, finish}, 0);

        // abort from pause clears the score
        song_sel = 1; start_btn = 1; step();
        judge_r = 1; red_hit = 1; step();
        chk("abort_pre", score, 10);
        pause_btn = 1; step();
        start_btn = 1; pause_btn = 1; step();
        chk("abort_score", score, 0);
        chk("abort_idle", {playing, cur_song}, 0);

        // song 2: one hit per note until combo saturates
        song_sel = 2; start_btn = 1; step();
        judge_r = 1;
        for (int i = 0; i < 6000; i++) begin
            red_hit = (m_st == S_PLAY) && (m_ticks % 7 == 3) && (m_phase == 0);
            step();
            if (finish) break;
        end
        chk("sat_fin", finish, 1);
        chk("sat_combo", combo, 255);
        chk("sat_max", max_combo, 255);
        start_btn = 1; step();

        // randomized traffic
        for (int i = 0; i < 20000; i++) begin
            rst       = ($urandom_range(0, 3999) == 0);
            start_btn = ($urandom_range(0, 59) == 0);
            pause_btn = ($urandom_range(0, 79) == 0);
            song_sel  = 2'($urandom_range(0, 3));
            red_hit   = ($urandom_range(0, 5) == 0);
            blue_hit  = ($urandom_range(0, 5) == 0);
            judge_r   = 1'($urandom_range(0, 1));
            judge_b   = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
